// File: rtl/lfsr_symbol_gen.sv
// Pseudo-random symbol source: Fibonacci LFSR with a valid/ready output, runtime reseed,
// mark/rewind snapshot for replaying a round, and a saturating accepted-symbol counter.
module lfsr_symbol_gen #(
   parameter int unsigned       WIDTH = 16,
   parameter logic [WIDTH-1:0]  TAPS  = 16'hB400,
   parameter logic [WIDTH-1:0]  SEED  = 16'hACE1,
   parameter int unsigned       SYM_W = 2,
   parameter int unsigned       CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             mark,
   input  logic             rewind,
   output logic             sym_valid,
   input  logic             sym_ready,
   output logic [SYM_W-1:0] sym_data,
   output logic [CNT_W-1:0] sym_count
);

   typedef enum logic {StSettle, StRun} fsm_e;

   fsm_e             fsm_q;
   logic             valid_q;
   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] snap_q;
   logic [CNT_W-1:0] count_q;

   logic [WIDTH-1:0] state_adv;
   logic [WIDTH-1:0] seed_val;
   logic [CNT_W-1:0] count_inc;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], ^(s & TAPS)};
   endfunction

   // One accept consumes SYM_W fresh bits, so unroll that many single steps.
   function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] r;
      r = s;
      for (int unsigned i = 0; i < SYM_W; i++) begin
         r = lfsr_step(r);
      end
      return r;
   endfunction

   always_comb begin
      state_adv = lfsr_advance(state_q);
      // A zero seed would lock the LFSR, so fall back to the default seed.
      seed_val  = (seed_in == '0) ? SEED : seed_in;
      count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= StSettle;
         valid_q <= 1'b0;
         state_q <= SEED;
         snap_q  <= SEED;
         count_q <= '0;
      end else if (seed_load) begin
         fsm_q   <= StSettle;
         valid_q <= 1'b0;
         state_q <= seed_val;
         snap_q  <= seed_val;
         count_q <= '0;
      end else if (rewind) begin
         fsm_q   <= StSettle;
         valid_q <= 1'b0;
         state_q <= snap_q;
         count_q <= '0;
      end else begin
         if (mark) begin
            snap_q  <= state_q;
            count_q <= '0;
         end
         unique case (fsm_q)
            StSettle: begin
               fsm_q   <= StRun;
               valid_q <= 1'b1;
            end
            StRun: begin
               if (state_q == '0) begin
                  state_q <= SEED;
               end else if (sym_ready) begin
                  state_q <= state_adv;
                  // The accept in a mark cycle is the first symbol of the new round.
                  count_q <= mark ? CNT_W'(1) : count_inc;
               end
            end
         endcase
      end
   end

   assign sym_valid = valid_q;
   assign sym_data  = state_q[SYM_W-1:0];
   assign sym_count = count_q;

endmodule

// File: tb/tb_lfsr_symbol_gen.sv
// Scoreboard bench for lfsr_symbol_gen: expected symbols are queued as stimulus is driven
// and checked on every handshake; a second instance with a 4-bit counter covers saturation.
module tb_lfsr_symbol_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       seed_load;
   logic [3:0] seed_in;
   logic       mark;
   logic       rewind;
   logic       sym_ready;
   logic       sym_valid;
   logic [1:0] sym_data;
   logic [7:0] sym_count;
   logic       sym_valid_s;
   logic [1:0] sym_data_s;
   logic [3:0] sym_count_s;

   int tests = 0;
   int fails = 0;
   logic [1:0] exp_q[$];
   logic [3:0] mdl;

   lfsr_symbol_gen #(
      .WIDTH (4), .TAPS (4'b1100), .SEED (4'b1011), .SYM_W (2), .CNT_W (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .mark      (mark),
      .rewind    (rewind),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .sym_data  (sym_data),
      .sym_count (sym_count)
   );

   lfsr_symbol_gen #(
      .WIDTH (4), .TAPS (4'b1100), .SEED (4'b1011), .SYM_W (2), .CNT_W (4)
   ) dut_sat (
      .clk       (clk),
      .rst       (rst),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .mark      (mark),
      .rewind    (rewind),
      .sym_valid (sym_valid_s),
      .sym_ready (sym_ready),
      .sym_data  (sym_data_s),
      .sym_count (sym_count_s)
   );

   always #5 clk = ~clk;

   // Reference: two Fibonacci steps, feedback = s[3]^s[2] for taps 1100.
   function automatic logic [3:0] adv(input logic [3:0] s);
      logic [3:0] r;
      r = s;
      for (int i = 0; i < 2; i++) r = {r[2:0], r[3] ^ r[2]};
      return r;
   endfunction

   task automatic push_n(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(mdl[1:0]);
         mdl = adv(mdl);
      end
   endtask

   // Checks any handshake in the current cycle against the scoreboard, then clocks once.
   task automatic step();
      logic [1:0] e;
      if (sym_valid && sym_ready && !seed_load && !rewind) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_empty: accepted sym %0d, no expected symbol queued", sym_data);
         end else begin
            e = exp_q.pop_front();
            if (sym_data !== e) begin
               fails++;
               $display("FAIL sb_sym: got %0d want %0d", sym_data, e);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int max);
      int n;
      n = 0;
      while (!sym_valid && n < max) begin
         step();
         n++;
      end
      tests++;
      if (sym_valid !== 1'b1) begin
         fails++;
         $display("FAIL wait_valid: sym_valid=%0b after %0d cycles, want 1", sym_valid, n);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; seed_load = 1'b0; seed_in = 4'd0; mark = 1'b0; rewind = 1'b0;
      sym_ready = 1'b0;
      exp_q.delete();
      mdl = 4'b1011;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; seed_load = 1'b0; seed_in = 4'd0; mark = 1'b0; rewind = 1'b0;
      sym_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (sym_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b want 0", sym_valid); end
      tests++; if (sym_count !== 8'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", sym_count); end
      tests++; if (sym_data !== 2'd3) begin fails++; $display("FAIL rst_data: got %0d want 3", sym_data); end
      tests++; if (dut.state_q !== 4'b1011) begin fails++; $display("FAIL rst_state: got %b want 1011", dut.state_q); end
      rst = 1'b0;
      tests++; if (sym_valid !== 1'b0) begin fails++; $display("FAIL settle_valid: got %0b want 0", sym_valid); end
      step();
      tests++; if (sym_valid !== 1'b1) begin fails++; $display("FAIL run_valid: got %0b want 1", sym_valid); end
   endtask

   task automatic test_basic();
      logic [3:0] st_exp[4];
      st_exp = '{4'b1011, 4'b1111, 4'b1100, 4'b0001};
      do_reset();
      sym_ready = 1'b1;
      tests++; if (sym_valid !== 1'b0) begin fails++; $display("FAIL basic_settle: got %0b want 0", sym_valid); end
      step();
      tests++; if (sym_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %0b want 1", sym_valid); end
      push_n(4);
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (dut.state_q !== st_exp[i]) begin
            fails++; $display("FAIL basic_state%0d: got %b want %b", i, dut.state_q, st_exp[i]);
         end
         step();
      end
      tests++; if (sym_count !== 8'd4) begin fails++; $display("FAIL basic_count: got %0d want 4", sym_count); end
   endtask

   task automatic test_stall();
      do_reset();
      wait_valid(4);
      sym_ready = 1'b1;
      push_n(4);
      step();
      sym_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tests++; if (sym_data !== 2'd3) begin fails++; $display("FAIL stall_data: got %0d want 3", sym_data); end
         tests++; if (dut.state_q !== 4'b1111) begin fails++; $display("FAIL stall_state: got %b want 1111", dut.state_q); end
         step();
      end
      sym_ready = 1'b1;
      repeat (3) step();
      sym_ready = 1'b0;
      tests++; if (sym_count !== 8'd4) begin fails++; $display("FAIL stall_count: got %0d want 4", sym_count); end
      tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL stall_left: %0d symbols left want 0", exp_q.size()); end
   endtask

   task automatic test_mark_rewind();
      do_reset();
      wait_valid(4);
      mark = 1'b1; step(); mark = 1'b0;
      tests++; if (sym_count !== 8'd0) begin fails++; $display("FAIL mark_count: got %0d want 0", sym_count); end
      sym_ready = 1'b1; push_n(3); repeat (3) step(); sym_ready = 1'b0;
      tests++; if (sym_count !== 8'd3) begin fails++; $display("FAIL mark_acc3: got %0d want 3", sym_count); end
      rewind = 1'b1; step(); rewind = 1'b0;
      tests++; if (sym_valid !== 1'b0) begin fails++; $display("FAIL rew_valid: got %0b want 0", sym_valid); end
      tests++; if (sym_count !== 8'd0) begin fails++; $display("FAIL rew_count: got %0d want 0", sym_count); end
      step();
      tests++; if (sym_valid !== 1'b1) begin fails++; $display("FAIL rew_run: got %0b want 1", sym_valid); end
      mdl = 4'b1011; push_n(3);
      sym_ready = 1'b1; repeat (3) step(); sym_ready = 1'b0;
      // Mark in the same cycle as an accept of symbol 1 (state 0001).
      mark = 1'b1; sym_ready = 1'b1; push_n(1); step(); mark = 1'b0;
      tests++; if (sym_count !== 8'd1) begin fails++; $display("FAIL markacc_count: got %0d want 1", sym_count); end
      push_n(2); repeat (2) step(); sym_ready = 1'b0;
      tests++; if (sym_count !== 8'd3) begin fails++; $display("FAIL markacc_acc3: got %0d want 3", sym_count); end
      rewind = 1'b1; step(); rewind = 1'b0;
      step();
      mdl = 4'b0001; push_n(3);
      sym_ready = 1'b1; repeat (3) step(); sym_ready = 1'b0;
      tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rew_left: %0d symbols left want 0", exp_q.size()); end
   endtask

   task automatic test_reseed();
      do_reset();
      sym_ready = 1'b1;
      wait_valid(4);
      push_n(2); repeat (2) step();
      seed_in = 4'd0; seed_load = 1'b1; step(); seed_load = 1'b0;
      tests++; if (dut.state_q !== 4'b1011) begin fails++; $display("FAIL seed0_state: got %b want 1011", dut.state_q); end
      tests++; if (sym_valid !== 1'b0) begin fails++; $display("FAIL seed0_valid: got %0b want 0", sym_valid); end
      tests++; if (sym_count !== 8'd0) begin fails++; $display("FAIL seed0_count: got %0d want 0", sym_count); end
      step();
      mdl = 4'b1011; push_n(4); repeat (4) step();
      tests++; if (sym_count !== 8'd4) begin fails++; $display("FAIL seed0_acc4: got %0d want 4", sym_count); end
      seed_in = 4'b0001; seed_load = 1'b1; rewind = 1'b1; step(); seed_load = 1'b0; rewind = 1'b0;
      tests++; if (dut.state_q !== 4'b0001) begin fails++; $display("FAIL seedrew_state: got %b want 0001", dut.state_q); end
      step();
      tests++; if (sym_data !== 2'd1) begin fails++; $display("FAIL seed1_first: got %0d want 1", sym_data); end
      mdl = 4'b0001; push_n(2); repeat (2) step();
      rewind = 1'b1; step(); rewind = 1'b0;
      tests++; if (dut.state_q !== 4'b0001) begin fails++; $display("FAIL seed_snap: got %b want 0001", dut.state_q); end
      step();
      mdl = 4'b0001; push_n(1); step(); sym_ready = 1'b0;
      tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL seed_left: %0d symbols left want 0", exp_q.size()); end
   endtask

   task automatic test_period();
      logic [1:0] seen[30];
      do_reset();
      wait_valid(4);
      sym_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         seen[i] = sym_data;
         tests++; if (dut.state_q === 4'd0) begin fails++; $display("FAIL period_zero: state 0000 at accept %0d", i); end
         push_n(1);
         step();
      end
      sym_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tests++;
         if (seen[i] !== seen[i+15]) begin
            fails++; $display("FAIL period_rep%0d: got %0d want %0d", i, seen[i+15], seen[i]);
         end
      end
      tests++; if (dut.state_q !== 4'b1011) begin fails++; $display("FAIL period_wrap: got %b want 1011", dut.state_q); end
   endtask

   task automatic test_saturation();
      do_reset();
      wait_valid(4);
      sym_ready = 1'b1;
      push_n(20);
      repeat (14) step();
      tests++; if (sym_count_s !== 4'd14) begin fails++; $display("FAIL sat_14: got %0d want 14", sym_count_s); end
      repeat (6) step();
      sym_ready = 1'b0;
      tests++; if (sym_count_s !== 4'd15) begin fails++; $display("FAIL sat_15: got %0d want 15", sym_count_s); end
      tests++; if (sym_count !== 8'd20) begin fails++; $display("FAIL sat_wide: got %0d want 20", sym_count); end
      tests++; if (sym_valid_s !== 1'b1) begin fails++; $display("FAIL sat_valid: got %0b want 1", sym_valid_s); end
      tests++; if (sym_data_s !== mdl[1:0]) begin fails++; $display("FAIL sat_data: got %0d want %0d", sym_data_s, mdl[1:0]); end
   endtask

   task automatic test_async_reset();
      do_reset();
      wait_valid(4);
      sym_ready = 1'b1;
      push_n(3); repeat (3) step();
      #2;
      rst = 1'b1;
      #1;
      tests++; if (sym_valid !== 1'b0) begin fails++; $display("FAIL arst_valid: got %0b want 0", sym_valid); end
      tests++; if (sym_count !== 8'd0) begin fails++; $display("FAIL arst_count: got %0d want 0", sym_count); end
      tests++; if (sym_count_s !== 4'd0) begin fails++; $display("FAIL arst_count_s: got %0d want 0", sym_count_s); end
      exp_q.delete();
      mdl = 4'b1011;
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests++; if (sym_valid !== 1'b0) begin fails++; $display("FAIL arst_settle: got %0b want 0", sym_valid); end
      @(posedge clk);
      #1;
      tests++; if (sym_valid !== 1'b1) begin fails++; $display("FAIL arst_run: got %0b want 1", sym_valid); end
      push_n(4); repeat (4) step();
      sym_ready = 1'b0;
      tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL arst_left: %0d symbols left want 0", exp_q.size()); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_mark_rewind();
      test_reseed();
      test_period();
      test_saturation();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
